// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline-side request/response and word-memory port bundle.
// Revision 1.0
`default_nettype none

interface mem_access_ctrl_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport master (
    output req, wr, size, sign, addr, wdata, mem_dout,
    input  busy, done, err, rdata, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  req, wr, size, sign, addr, wdata, mem_dout,
    output busy, done, err, rdata, mem_we, mem_addr, mem_din
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/halfword/word load-store unit over a word memory, RMW for sub-word stores.
// Revision 1.0
`default_nettype none

module mem_access_ctrl #(
  parameter int ADDR_LIMIT = 128
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state, state_nx;
  logic        wr_q, sign_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q, merge_q, rdata_q, mem_addr_q;
  logic        done_q, err_q;

  logic        accept, bad, misaligned, busy, mem_we;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val, merge_val;

  assign accept = ((state == IDLE) || (state == FAULT)) && bus.req;

  always_comb begin
    case (bus.size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  assign misaligned = ((bus.size == SZ_HALF) && bus.addr[0]) ||
                      ((bus.size == SZ_WORD) && (bus.addr[1:0] != 2'b00));
  // Widened sum so an address near 2^32 cannot wrap past the limit check.
  assign end_addr   = {1'b0, bus.addr} + {30'd0, nbytes};
  assign bad        = (bus.size == 2'b11) || misaligned || (end_addr > 33'(ADDR_LIMIT));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    mem_we   = 1'b0;
    case (state)
      IDLE, FAULT: begin
        state_nx = IDLE;
        if (bus.req) state_nx = bad ? FAULT : ACCESS;
      end
      ACCESS: begin
        busy     = 1'b1;
        mem_we   = wr_q && (size_q == SZ_WORD);
        state_nx = (wr_q && (size_q != SZ_WORD)) ? WRITE : IDLE;
      end
      WRITE: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = bus.mem_dout[7:0];
      2'd1:    rd_byte = bus.mem_dout[15:8];
      2'd2:    rd_byte = bus.mem_dout[23:16];
      default: rd_byte = bus.mem_dout[31:24];
    endcase
    rd_half = lane_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];

    case (size_q)
      SZ_BYTE: load_val = sign_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      SZ_HALF: load_val = sign_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      default: load_val = bus.mem_dout;
    endcase

    merge_val = bus.mem_dout;
    if (size_q == SZ_BYTE) begin
      case (lane_q)
        2'd0:    merge_val[7:0]   = wdata_q[7:0];
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merge_val[31:16] = wdata_q[15:0];
    end else begin
      merge_val[15:0]  = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      wdata_q    <= 32'd0;
      merge_q    <= 32'd0;
      rdata_q    <= 32'd0;
      mem_addr_q <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        wr_q       <= bus.wr;
        sign_q     <= bus.sign;
        size_q     <= bus.size;
        lane_q     <= bus.addr[1:0];
        wdata_q    <= bus.wdata;
        mem_addr_q <= {bus.addr[31:2], 2'b00};
        done_q     <= bad;
        err_q      <= bad;
      end
      if (state == ACCESS) begin
        if (!wr_q) rdata_q <= load_val;
        if (state_nx == WRITE) merge_q <= merge_val;
        else done_q <= 1'b1;
      end
      if (state == WRITE) done_q <= 1'b1;
    end
  end

  assign bus.busy     = busy;
  assign bus.mem_we   = mem_we;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = mem_addr_q;
  // Word stores drive the latched data; the merge register only matters in WRITE.
  assign bus.mem_din  = (state == WRITE) ? merge_q : wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl with a 32-word memory model.
// Revision 1.0
`default_nettype none

module tb_mem_access_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  int   we_cnt;

  logic [31:0] mem [0:31] = '{default: 32'd0};

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.ADDR_LIMIT(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_dout = mem[bus.mem_addr[6:2]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[6:2]] <= bus.mem_din;
  end

  always @(negedge clk) begin
    if (bus.mem_we) we_cnt = we_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic drive_req(input logic w, input logic [1:0] s, input logic sg,
                           input logic [31:0] a, input logic [31:0] d);
    bus.req = 1'b1; bus.wr = w; bus.size = s; bus.sign = sg; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %h exp 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rst_done got %h exp 0", bus.done); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL rst_err got %h exp 0", bus.err); else passed++;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL rst_we got %h exp 0", bus.mem_we); else passed++;
    checks++; if (bus.rdata !== 32'd0) $display("FAIL rst_rdata got %h exp 0", bus.rdata); else passed++;
    checks++; if (bus.mem_addr !== 32'd0) $display("FAIL rst_maddr got %h exp 0", bus.mem_addr); else passed++;
    checks++; if (bus.mem_din !== 32'd0) $display("FAIL rst_mdin got %h exp 0", bus.mem_din); else passed++;
    rst = 1'b0;
    // Reset and request in the same cycle: the request must be dropped.
    rst = 1'b1;
    drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL rstreq_busy got %h exp 0", bus.busy); else passed++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) $display("FAIL rstreq_done got %h exp 0", bus.done); else passed++;
  endtask

  task automatic test_word_store_load;
    int snap;
    snap = we_cnt;
    drive_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1) $display("FAIL sw_we got %h exp 1", bus.mem_we); else passed++;
    checks++; if (bus.mem_din !== 32'hDEADBEEF) $display("FAIL sw_din got %h exp deadbeef", bus.mem_din); else passed++;
    checks++; if (bus.mem_addr !== 32'h10) $display("FAIL sw_addr got %h exp 10", bus.mem_addr); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL sw_busy got %h exp 1", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL sw_early_done got %h exp 0", bus.done); else passed++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) $display("FAIL sw_done got %h exp 1", bus.done); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL sw_err got %h exp 0", bus.err); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL sw_idle_busy got %h exp 0", bus.busy); else passed++;
    checks++; if (we_cnt - snap !== 1) $display("FAIL sw_we_cycles got %0d exp 1", we_cnt - snap); else passed++;
    drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) $display("FAIL lw_early_done got %h exp 0", bus.done); else passed++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) $display("FAIL lw_done got %h exp 1", bus.done); else passed++;
    checks++; if (bus.rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata got %h exp deadbeef", bus.rdata); else passed++;
  endtask

  task automatic test_rmw_and_ext;
    logic [1:0]  sz  [5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    logic        sg  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad  [5] = '{32'h22, 32'h22, 32'h20, 32'h23, 32'h20};
    logic [31:0] ex  [5] = '{32'hFFFFFFAA, 32'h000011AA, 32'h00003344, 32'h00000011, 32'h11AA3344};
    drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    repeat (2) @(negedge clk);
    drive_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AA);
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL rmw_rd_we got %h exp 0", bus.mem_we); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL rmw_busy got %h exp 1", bus.busy); else passed++;
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1) $display("FAIL rmw_wr_we got %h exp 1", bus.mem_we); else passed++;
    checks++; if (bus.mem_din !== 32'h11AA3344) $display("FAIL rmw_din got %h exp 11aa3344", bus.mem_din); else passed++;
    checks++; if (bus.mem_addr !== 32'h20) $display("FAIL rmw_addr got %h exp 20", bus.mem_addr); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rmw_early_done got %h exp 0", bus.done); else passed++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) $display("FAIL rmw_done got %h exp 1", bus.done); else passed++;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL rmw_idle_we got %h exp 0", bus.mem_we); else passed++;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, sz[i], sg[i], ad[i], 32'd0);
      repeat (2) @(negedge clk);
      checks++; if (bus.done !== 1'b1) $display("FAIL ld%0d_done got %h exp 1", i, bus.done); else passed++;
      checks++; if (bus.rdata !== ex[i]) $display("FAIL ld%0d_rdata got %h exp %h", i, bus.rdata, ex[i]); else passed++;
    end
  endtask

  task automatic test_errors;
    int snap;
    snap = we_cnt;
    drive_req(1'b0, 2'b10, 1'b0, 32'h12, 32'd0);
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) $display("FAIL mis_done got %h exp 1", bus.done); else passed++;
    checks++; if (bus.err !== 1'b1) $display("FAIL mis_err got %h exp 1", bus.err); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL mis_busy got %h exp 0", bus.busy); else passed++;
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) $display("FAIL mis_err_len got %h exp 0", bus.err); else passed++;
    checks++; if (bus.rdata !== 32'h11AA3344) $display("FAIL mis_rdata got %h exp 11aa3344", bus.rdata); else passed++;
    drive_req(1'b1, 2'b00, 1'b0, 32'h80, 32'h5A);
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) $display("FAIL oob_err got %h exp 1", bus.err); else passed++;
    @(negedge clk);
    checks++; if (we_cnt - snap !== 0) $display("FAIL err_we_cycles got %0d exp 0", we_cnt - snap); else passed++;
    drive_req(1'b0, 2'b11, 1'b0, 32'h20, 32'd0);
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) $display("FAIL sz11_err got %h exp 1", bus.err); else passed++;
    drive_req(1'b0, 2'b01, 1'b0, 32'h21, 32'd0);
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) $display("FAIL half_mis_err got %h exp 1", bus.err); else passed++;
    drive_req(1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFEF00D);
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) $display("FAIL top_word_err got %h exp 0", bus.err); else passed++;
    checks++; if (bus.mem_we !== 1'b1) $display("FAIL top_word_we got %h exp 1", bus.mem_we); else passed++;
    @(negedge clk);
    drive_req(1'b0, 2'b00, 1'b1, 32'h7F, 32'd0);
    repeat (2) @(negedge clk);
    checks++; if (bus.err !== 1'b0) $display("FAIL top_byte_err got %h exp 0", bus.err); else passed++;
    checks++; if (bus.rdata !== 32'hFFFFFFCA) $display("FAIL top_byte_rdata got %h exp ffffffca", bus.rdata); else passed++;
    drive_req(1'b0, 2'b01, 1'b0, 32'h7E, 32'd0);
    repeat (2) @(negedge clk);
    checks++; if (bus.rdata !== 32'h0000CAFE) $display("FAIL top_half_rdata got %h exp 0000cafe", bus.rdata); else passed++;
    // A request held through the FAULT cycle is accepted there.
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'b10; bus.sign = 1'b0; bus.addr = 32'h12;
    @(posedge clk);
    #1 bus.size = 2'b00; bus.addr = 32'h20;
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) $display("FAIL flt_b2b_err got %h exp 1", bus.err); else passed++;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("FAIL flt_b2b_busy got %h exp 1", bus.busy); else passed++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) $display("FAIL flt_b2b_done got %h exp 1", bus.done); else passed++;
    checks++; if (bus.rdata !== 32'h00000044) $display("FAIL flt_b2b_rdata got %h exp 44", bus.rdata); else passed++;
  endtask

  task automatic test_busy_hold;
    logic [7:0] hist;
    hist = 8'd0;
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b00; bus.sign = 1'b0; bus.addr = 32'h24; bus.wdata = 32'h55;
    @(posedge clk);
    #1 bus.wr = 1'b0; bus.size = 2'b10; bus.wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      hist[i] = bus.done;
      if (i == 1) begin
        checks++; if (bus.mem_din !== 32'h00000055) $display("FAIL busy_din got %h exp 55", bus.mem_din); else passed++;
      end
      if (i == 2) begin
        @(posedge clk);
        #1 bus.req = 1'b0;
      end
    end
    checks++; if (hist !== 8'b0001_0100) $display("FAIL busy_done_hist got %b exp 00010100", hist); else passed++;
    checks++; if (bus.rdata !== 32'h00000055) $display("FAIL busy_rdata got %h exp 55", bus.rdata); else passed++;
  endtask

  task automatic test_reset_in_write;
    drive_req(1'b1, 2'b00, 1'b0, 32'h28, 32'h77);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1) $display("FAIL rw_inwrite_we got %h exp 1", bus.mem_we); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL rw_we got %h exp 0", bus.mem_we); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rw_busy got %h exp 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rw_done got %h exp 0", bus.done); else passed++;
    checks++; if (bus.rdata !== 32'd0) $display("FAIL rw_rdata got %h exp 0", bus.rdata); else passed++;
    checks++; if (bus.mem_din !== 32'd0) $display("FAIL rw_mdin got %h exp 0", bus.mem_din); else passed++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) $display("FAIL rw_late_done got %h exp 0", bus.done); else passed++;
    drive_req(1'b0, 2'b10, 1'b0, 32'h28, 32'd0);
    repeat (2) @(negedge clk);
    checks++; if (bus.done !== 1'b1) $display("FAIL rw_ld_done got %h exp 1", bus.done); else passed++;
    checks++; if (bus.rdata !== 32'h00000077) $display("FAIL rw_ld_rdata got %h exp 77", bus.rdata); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; we_cnt = 0;
    rst = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.sign = 1'b0;
    bus.addr = 32'd0; bus.wdata = 32'd0;
    test_reset();
    test_word_store_load();
    test_rmw_and_ext();
    test_errors();
    test_busy_hold();
    test_reset_in_write();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_LIMIT, 128, byte size of the attached data memory; accesses at or above it are errors.
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 Req  input  1  access request from the pipeline MEM stage; sampled only while Busy=0.
REQ-005 Wr  input  1  1=store, 0=load.
REQ-006 Size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is an error.
REQ-007 Sign  input  1  loads only: 1 sign-extends, 0 zero-extends.
REQ-008 Addr  input  32  byte address.
REQ-009 Wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-010 Busy  output  1  1 while a request is in progress; no new request is accepted.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 Err  output  1  one-cycle error pulse, coincident with Done.
REQ-013 Rdata  output  32  extended load result; valid from the Done cycle until the next load completes.
REQ-014 MemWe  output  1  write enable to the word memory.
REQ-015 MemAddr  output  32  word-aligned address to the memory: {Addr[31:2],2'b00}.
REQ-016 MemDin  output  32  write data to the memory.
REQ-017 MemDout  input  32  combinational read data from the memory at MemAddr.

Function
REQ-018 The FSM SHALL have four states: IDLE, ACCESS, WRITE and FAULT.
- Busy=1 in ACCESS and WRITE.
- Busy=0 in IDLE and FAULT.
REQ-019 IDLE with Req=1 at an edge SHALL latch Wr, Size, Sign, Addr and Wdata.
- Next state is FAULT if the request is misaligned, has Size=11, or has Addr+bytes > ADDR_LIMIT.
- Otherwise the next state is ACCESS.
REQ-020 Misaligned SHALL mean halfword with Addr[0]=1, or word with Addr[1:0]!=00.
REQ-021 FAULT SHALL last one cycle with Done=1 and Err=1, then go to IDLE.
- MemWe stays 0.
- Rdata is unchanged.
- A Req present in the FAULT cycle SHALL be accepted, because Busy=0.
REQ-022 ACCESS, word store: MemWe=1, MemDin=latched Wdata; next state IDLE with Done=1 in the following cycle.
REQ-023 ACCESS, load: MemWe=0.
- Rdata is registered from MemDout, byte lane Addr[1:0] (halfword lane Addr[1]), little-endian.
- Extension follows Sign.
- Next state IDLE with Done=1 in the following cycle.
REQ-024 ACCESS, byte or halfword store (read-modify-write):
- MemWe=0.
- A merge register SHALL capture MemDout with the addressed lane(s) replaced by Wdata[7:0] or Wdata[15:0].
- Next state is WRITE.
REQ-025 WRITE: MemWe=1, MemDin=merge register for the whole cycle; next state IDLE with Done=1 in the following cycle.
REQ-026 Latency from the accepting edge to Done:
- Error: 1 cycle.
- Load or word store: 2 cycles.
- Sub-word store: 3 cycles.
REQ-027 Done and Err SHALL be registered and never be high for two consecutive cycles for the same request.
- Back-to-back requests may produce Done in adjacent cycles.
REQ-028 MemAddr SHALL be held stable from ACCESS through WRITE.
- MemWe SHALL be 0 in IDLE and FAULT.
REQ-029 Req in any cycle with Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-030 Input changes after acceptance SHALL NOT affect the in-flight request.

Reset
REQ-031 Rst=1 at an edge SHALL force IDLE in any state, including mid-WRITE.
- Busy=0, Done=0, Err=0, MemWe=0.
- Rdata=0, MemAddr=0, MemDin=0, merge register=0.
REQ-032 Rst SHALL have priority over Req in the same cycle; that request is dropped.
REQ-033 Reset during WRITE SHALL deassert MemWe in the cycle after the reset edge.
- A partial merged write may already have occurred; the block does not undo it.

Verification
REQ-034 Word store then load: store Wdata=0xDEADBEEF at Addr=0x10, then load word at 0x10.
- Store: MemWe high exactly 1 cycle.
- Load: Done 2 cycles after acceptance, Rdata=0xDEADBEEF.
REQ-035 Byte read-modify-write: memory word at 0x20 = 0x11223344; store byte Wdata=0xAA at Addr=0x22.
- WRITE cycle: MemDin=0x11AA3344.
- Done 3 cycles after acceptance.
REQ-036 Sign extension on the word 0x11AA3344 at 0x20:
- Signed byte load at 0x22: Rdata=0xFFFFFFAA.
- Unsigned halfword load at 0x22: Rdata=0x000011AA.
REQ-037 Errors:
- Word load at 0x12: Done=Err=1 one cycle after acceptance, MemWe never 1, Rdata unchanged.
- Byte store at Addr=0x80 with ADDR_LIMIT=128: Err=1.
REQ-038 Busy handling: a second Req held high during a sub-word store is ignored until Busy falls.
- It is accepted on the first edge with Busy=0.
- Exactly two Done pulses result.
REQ-039 Reset in WRITE: Rst asserted during WRITE.
- Next cycle: MemWe=0, Busy=0, Done=0, state IDLE.
- A following load completes normally.
